// File: rtl/hex_key_entry.sv
`default_nettype none
// ============================================================================
// Module   : hex_key_entry
// Brief    : Debounced ENTER/CLEAR push buttons assemble a DATA_W-bit word
//            one hex nibble at a time and hand it to the DES core over a
//            valid/ready handshake. Also drives the 7-segment hex code.
// Revision : 1.0 - initial release
// ============================================================================
module hex_key_entry #(
  parameter int DATA_W          = 64,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        sw,
  input  logic              psh_enter,
  input  logic              psh_clear,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        digit_cnt,
  output logic [4:0]        disp_bcd
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]       LAST_NIB  = 5'(NIBBLES - 1);
  localparam logic [4:0]       DISP_BLANK = 5'd16;

  // Button index 0 is ENTER, index 1 is CLEAR.
  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [1:0]            w_raw;
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_db;
  logic [1:0]            r_press;
  logic [1:0][CNT_W-1:0] r_cnt;

  state_t                r_state;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic [4:0]            r_digits;
  logic [4:0]            r_disp;
  logic [DATA_W-1:0]     w_shift_next;

  assign w_raw        = {psh_clear, psh_enter};
  assign w_shift_next = {r_shift[DATA_W-5:0], sw};

  // Synchronize both buttons, then accept a new level only after it has
  // disagreed with the current debounced level for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int b = 0; b < 2; b++) begin
        r_press[b] <= 1'b0;
        if (r_sync2[b] != r_db[b]) begin
          if (r_cnt[b] == CNT_MAX) begin
            r_db[b]    <= r_sync2[b];
            r_cnt[b]   <= '0;
            // Only the rising debounced edge is a press; release is silent.
            r_press[b] <= r_sync2[b];
          end else begin
            r_cnt[b] <= r_cnt[b] + 1'b1;
          end
        end else begin
          r_cnt[b] <= '0;
        end
      end
    end
  end

  // Entry / handshake state machine; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ENTRY;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_digits <= '0;
      r_disp   <= DISP_BLANK;
    end else begin
      case (r_state)
        ST_ENTRY: begin
          if (r_press[BTN_CLEAR]) begin
            r_shift  <= '0;
            r_digits <= '0;
            r_disp   <= DISP_BLANK;
          end else if (r_press[BTN_ENTER]) begin
            r_shift  <= w_shift_next;
            r_digits <= r_digits + 5'd1;
            r_disp   <= {1'b0, sw};
            if (r_digits == LAST_NIB) begin
              // The word is frozen into data_out only when it is complete.
              r_data  <= w_shift_next;
              r_valid <= 1'b1;
              r_state <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          // Button presses are dropped here; only the consumer can release us.
          if (out_ready) begin
            r_valid  <= 1'b0;
            r_digits <= '0;
            r_disp   <= DISP_BLANK;
            r_state  <= ST_ENTRY;
          end
        end
        default: begin
          r_state <= ST_ENTRY;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign digit_cnt = r_digits;
  assign disp_bcd  = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_hex_key_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_key_entry
// Brief    : Self-checking bench for hex_key_entry (DATA_W=16, debounce 4).
//            A behavioural model predicts every output each cycle; directed
//            scenarios add literal expectations, then random button traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_key_entry;

  localparam int DATA_W = 16;
  localparam int DEB    = 4;
  localparam int NIB    = DATA_W / 4;
  localparam int HLEN   = DEB + 2;

  logic              clk;
  logic              rst_n;
  logic [3:0]        sw;
  logic              psh_enter;
  logic              psh_clear;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        digit_cnt;
  logic [4:0]        disp_bcd;

  hex_key_entry #(
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .psh_enter (psh_enter),
    .psh_clear (psh_clear),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit_cnt (digit_cnt),
    .disp_bcd  (disp_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples per button, oldest first; the debouncer sees a sample two
  // clocks after it was taken, so the newest two are not yet visible.
  int hist [2][HLEN];
  int lvl  [2];
  int pend [2];
  int nibs [$];
  bit m_full;
  int m_data;
  int m_disp;

  function automatic int packed_word();
    int w = 0;
    foreach (nibs[i]) w = (w << 4) | nibs[i];
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < HLEN; i++) hist[b][i] = 0;
        lvl[b]  = 0;
        pend[b] = 0;
      end
      nibs.delete();
      m_full = 1'b0;
      m_data = 0;
      m_disp = 16;
    end else begin
      // Word assembly reacts to presses recognised on the previous edge.
      if (!m_full) begin
        if (pend[1] != 0) begin
          nibs.delete();
          m_disp = 16;
        end else if (pend[0] != 0) begin
          nibs.push_back(int'(sw));
          m_disp = int'(sw);
          if (nibs.size() == NIB) begin
            m_full = 1'b1;
            m_data = packed_word();
          end
        end
      end else if (out_ready) begin
        m_full = 1'b0;
        nibs.delete();
        m_disp = 16;
      end
      // Debounce: level flips once DEB visible samples all disagree with it.
      for (int b = 0; b < 2; b++) begin
        bit flip;
        for (int i = 0; i < HLEN - 1; i++) hist[b][i] = hist[b][i+1];
        hist[b][HLEN-1] = (b == 0) ? int'(psh_enter) : int'(psh_clear);
        flip = 1'b1;
        for (int i = 0; i < DEB; i++) if (hist[b][i] == lvl[b]) flip = 1'b0;
        pend[b] = (flip && lvl[b] == 0) ? 1 : 0;
        if (flip) lvl[b] = 1 - lvl[b];
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc data_out",  32'(data_out),  32'(m_data));
      chk("cyc out_valid", 32'(out_valid), 32'(m_full));
      chk("cyc digit_cnt", 32'(digit_cnt), 32'(nibs.size()));
      chk("cyc disp_bcd",  32'(disp_bcd),  32'(m_disp));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input bit is_clear, input logic [3:0] val);
    sw = val;
    if (is_clear) psh_clear = 1'b1; else psh_enter = 1'b1;
    repeat (8) tick();
    psh_clear = 1'b0;
    psh_enter = 1'b0;
    repeat (8) tick();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk({name, " dut"}, act, exp);
    chk({name, " model"}, mdl, exp);
  endtask

  int run_e, run_c;

  initial begin
    rst_n     = 1'b0;
    sw        = 4'h0;
    psh_enter = 1'b0;
    psh_clear = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    lit("reset digit_cnt", 32'(digit_cnt), 32'(nibs.size()), 32'd0);
    lit("reset disp_bcd",  32'(disp_bcd),  32'(m_disp),      32'd16);
    rst_n = 1'b1;
    tick();

    // Four clean nibbles fill the word.
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 4'(4'hA + i));
      lit("fill digit_cnt", 32'(digit_cnt), 32'(nibs.size()), 32'(i + 1));
      lit("fill disp_bcd",  32'(disp_bcd),  32'(m_disp),      32'(5'h0A + i));
    end
    lit("full out_valid", 32'(out_valid), 32'(m_full), 32'd1);
    lit("full data_out",  32'(data_out),  32'(m_data), 32'hABCD);

    // Presses while FULL are dropped; then the consumer takes the word.
    press(1'b0, 4'h5);
    press(1'b1, 4'h0);
    lit("held data_out",  32'(data_out),  32'(m_data),      32'hABCD);
    lit("held digit_cnt", 32'(digit_cnt), 32'(nibs.size()), 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    lit("accept out_valid", 32'(out_valid), 32'(m_full),      32'd0);
    lit("accept digit_cnt", 32'(digit_cnt), 32'(nibs.size()), 32'd0);
    lit("accept data_out",  32'(data_out),  32'(m_data),      32'hABCD);
    tick();

    // Bouncy ENTER: toggles every 2 cycles, then settles high.
    sw = 4'h7;
    for (int i = 0; i < 10; i++) begin
      psh_enter = ~psh_enter;
      repeat (2) tick();
    end
    psh_enter = 1'b1;
    repeat (10) tick();
    psh_enter = 1'b0;
    repeat (10) tick();
    lit("bounce digit_cnt", 32'(digit_cnt), 32'(nibs.size()), 32'd1);
    lit("bounce disp_bcd",  32'(disp_bcd),  32'(m_disp),      32'd7);
    press(1'b1, 4'h0);

    // Clear mid-word discards it.
    press(1'b0, 4'h1);
    press(1'b0, 4'h2);
    press(1'b1, 4'h0);
    lit("clear digit_cnt", 32'(digit_cnt), 32'(nibs.size()), 32'd0);
    lit("clear disp_bcd",  32'(disp_bcd),  32'(m_disp),      32'd16);
    for (int i = 0; i < 4; i++) press(1'b0, 4'(4'h3 + i));
    lit("word2 data_out", 32'(data_out), 32'(m_data), 32'h3456);
    accept();

    // Simultaneous clear and enter: clear wins, nothing shifted in.
    press(1'b0, 4'h9);
    sw        = 4'hF;
    psh_enter = 1'b1;
    psh_clear = 1'b1;
    repeat (8) tick();
    psh_enter = 1'b0;
    psh_clear = 1'b0;
    repeat (8) tick();
    lit("both digit_cnt", 32'(digit_cnt), 32'(nibs.size()), 32'd0);
    lit("both disp_bcd",  32'(disp_bcd),  32'(m_disp),      32'd16);
    press(1'b0, 4'h7);
    press(1'b0, 4'h8);
    press(1'b0, 4'h9);
    press(1'b0, 4'hE);
    lit("word3 data_out", 32'(data_out), 32'(m_data), 32'h789E);
    accept();

    // Asynchronous reset in the middle of a partial word.
    press(1'b0, 4'h1);
    press(1'b0, 4'h2);
    rst_n = 1'b0;
    #1;
    chk("async data_out",  32'(data_out),  32'h0);
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async digit_cnt", 32'(digit_cnt), 32'h0);
    chk("async disp_bcd",  32'(disp_bcd),  32'd16);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Random button traffic, switch values and consumer readiness.
    run_e = 0;
    run_c = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_e == 0) begin
        psh_enter = ($urandom_range(0, 1) == 1);
        run_e     = $urandom_range(1, 9);
      end
      if (run_c == 0) begin
        psh_clear = ($urandom_range(0, 7) == 0);
        run_c     = $urandom_range(1, 9);
      end
      run_e--;
      run_c--;
      sw        = 4'($urandom);
      out_ready = ($urandom_range(0, 5) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
